// File: rtl/combo_lock_pkg.sv
// Shared types and width helpers for the sequential combination lock.
package combo_lock_pkg;

   // Lock controller states.
   typedef enum logic [1:0] {
      PROGRAM = 2'd0,
      ARMED   = 2'd1,
      OPEN    = 2'd2,
      LOCKOUT = 2'd3
   } lock_state_t;

   // Bit width needed to index n items, never less than one bit.
   function automatic int clog2_min1(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/combo_lock_seq_key_press_detect.sv
// Rising-edge press detector: a key counts once until it returns to idle (0).
module key_press_detect #(
   parameter int DIGIT_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [DIGIT_W-1:0] key_i,
   output logic               press_o
);

   logic [DIGIT_W-1:0] key_prev_q;

   // Remember the previous keypad code on every edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_prev_q <= {DIGIT_W{1'b0}};
      end else begin
         key_prev_q <= key_i;
      end
   end

   assign press_o = (key_i != {DIGIT_W{1'b0}}) && (key_prev_q == {DIGIT_W{1'b0}});

endmodule

// File: rtl/combo_lock_seq.sv
// Sequential combination lock: learns a code, checks entries, locks out after
// repeated wrong digits and re-locks on a keypress while open.
module combo_lock_seq
   import combo_lock_pkg::*;
#(
   parameter int DIGIT_W        = 4,
   parameter int CODE_LEN       = 4,
   parameter int MAX_FAILS      = 3,
   parameter int LOCKOUT_CYCLES = 1000
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [DIGIT_W-1:0]                key_in,
   input  logic                              relock,
   input  logic                              master_clear,
   output logic                              unlocked,
   output logic                              programmed,
   output logic                              locked_out,
   output logic [clog2_min1(CODE_LEN)-1:0]   digit_idx
);

   localparam int IDX_W  = clog2_min1(CODE_LEN);
   localparam int FAIL_W = $clog2(MAX_FAILS + 1);
   localparam int TMR_W  = $clog2(LOCKOUT_CYCLES + 1);

   localparam logic [IDX_W-1:0]  IDX_ZERO  = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(CODE_LEN - 1);
   localparam logic [FAIL_W-1:0] FAIL_ZERO = {FAIL_W{1'b0}};
   localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAILS - 1);
   localparam logic [TMR_W-1:0]  TMR_ZERO  = {TMR_W{1'b0}};
   localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(LOCKOUT_CYCLES - 1);

   lock_state_t         state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [FAIL_W-1:0]   fail_cnt_q, fail_cnt_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [DIGIT_W-1:0]  code_q [CODE_LEN];
   logic                code_wr;
   logic                code_clr;
   logic                press;

   logic                unlocked_q;
   logic                programmed_q;
   logic                locked_out_q;
   logic [IDX_W-1:0]    digit_idx_q;

   key_press_detect #(
      .DIGIT_W (DIGIT_W)
   ) u_press (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_i   (key_in),
      .press_o (press)
   );

   // Next-state logic; priority is master_clear > relock in OPEN > press > timer.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      fail_cnt_d = fail_cnt_q;
      timer_d    = timer_q;
      code_wr    = 1'b0;
      code_clr   = 1'b0;
      if (master_clear) begin
         state_d    = PROGRAM;
         idx_d      = IDX_ZERO;
         fail_cnt_d = FAIL_ZERO;
         timer_d    = TMR_ZERO;
         code_clr   = 1'b1;
      end else if ((state_q == OPEN) && relock) begin
         state_d    = PROGRAM;
         idx_d      = IDX_ZERO;
         fail_cnt_d = FAIL_ZERO;
         code_clr   = 1'b1;
      end else begin
         case (state_q)
            PROGRAM: begin
               if (press) begin
                  code_wr = 1'b1;
                  if (idx_q == IDX_LAST) begin
                     idx_d   = IDX_ZERO;
                     state_d = ARMED;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else begin
                  idx_d = idx_q;
               end
            end
            ARMED: begin
               if (press) begin
                  if (key_in == code_q[idx_q]) begin
                     if (idx_q == IDX_LAST) begin
                        state_d    = OPEN;
                        idx_d      = IDX_ZERO;
                        fail_cnt_d = FAIL_ZERO;
                     end else begin
                        idx_d = idx_q + 1'b1;
                     end
                  end else begin
                     // A wrong digit restarts the entry; it is not reused as digit 0.
                     idx_d      = IDX_ZERO;
                     fail_cnt_d = fail_cnt_q + 1'b1;
                     if (fail_cnt_q == FAIL_LAST) begin
                        state_d = LOCKOUT;
                        timer_d = TMR_LOAD;
                     end else begin
                        state_d = ARMED;
                     end
                  end
               end else begin
                  idx_d = idx_q;
               end
            end
            OPEN: begin
               if (press) begin
                  state_d = ARMED;
                  idx_d   = IDX_ZERO;
               end else begin
                  state_d = OPEN;
               end
            end
            LOCKOUT: begin
               // Keypresses are ignored until the timer has run out.
               if (timer_q == TMR_ZERO) begin
                  state_d    = ARMED;
                  fail_cnt_d = FAIL_ZERO;
                  idx_d      = IDX_ZERO;
               end else begin
                  timer_d = timer_q - 1'b1;
               end
            end
            default: begin
               state_d = PROGRAM;
               idx_d   = IDX_ZERO;
            end
         endcase
      end
   end

   // State, digit index, fail counter and lockout timer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= PROGRAM;
         idx_q      <= IDX_ZERO;
         fail_cnt_q <= FAIL_ZERO;
         timer_q    <= TMR_ZERO;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         fail_cnt_q <= fail_cnt_d;
         timer_q    <= timer_d;
      end
   end

   // Stored combination; written digit by digit while programming.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CODE_LEN; i++) begin
            code_q[i] <= {DIGIT_W{1'b0}};
         end
      end else if (code_clr) begin
         for (int i = 0; i < CODE_LEN; i++) begin
            code_q[i] <= {DIGIT_W{1'b0}};
         end
      end else if (code_wr) begin
         code_q[idx_q] <= key_in;
      end
   end

   // Registered output decodes, taken from the next state so they track state_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         unlocked_q   <= 1'b0;
         programmed_q <= 1'b0;
         locked_out_q <= 1'b0;
         digit_idx_q  <= IDX_ZERO;
      end else begin
         unlocked_q   <= (state_d == OPEN);
         programmed_q <= (state_d != PROGRAM);
         locked_out_q <= (state_d == LOCKOUT);
         digit_idx_q  <= idx_d;
      end
   end

   assign unlocked   = unlocked_q;
   assign programmed = programmed_q;
   assign locked_out = locked_out_q;
   assign digit_idx  = digit_idx_q;

endmodule
